// File: rtl/ysyx_220066_mem_pkg.sv
// Shared types and constants for the ysyx_220066 memory arbiter.
// Covers FSM states, MemOp codes and owner encoding.
package ysyx_220066_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LD  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LWU = 3'b110;

    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_SD  = 3'b011;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Byte-lane strobe for an access of 2^size bytes at offset 0.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        unique case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        unique case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_220066_mem_align.sv
// Combinational lane steering, load extension and access checking.
// Stores shift into the 64-bit word; loads shift back and extend.
module ysyx_220066_mem_align
    import ysyx_220066_mem_pkg::*;
(
    input  logic        is_if,
    input  logic        wen,
    input  logic [2:0]  memop,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] st_data,
    output logic [7:0]  st_strb,
    output logic [63:0] ld_data,
    output logic [31:0] if_data,
    output logic        acc_err
);

    logic [1:0]  size;
    logic [63:0] ld_sh;
    logic        mis;
    logic        ill;

    assign size = memop[1:0];

    always_comb begin
        st_data = '0;
        st_strb = '0;
        if (wen) begin
            st_data = wdata << {addr_lo, 3'b000};
            st_strb = lane_mask(size) << addr_lo;
        end
    end

    always_comb begin
        ld_sh   = rdata >> {addr_lo, 3'b000};
        ld_data = '0;
        unique case (memop)
            OP_LB:   ld_data = {{56{ld_sh[7]}}, ld_sh[7:0]};
            OP_LH:   ld_data = {{48{ld_sh[15]}}, ld_sh[15:0]};
            OP_LW:   ld_data = {{32{ld_sh[31]}}, ld_sh[31:0]};
            OP_LD:   ld_data = ld_sh;
            OP_LBU:  ld_data = {56'd0, ld_sh[7:0]};
            OP_LHU:  ld_data = {48'd0, ld_sh[15:0]};
            OP_LWU:  ld_data = {32'd0, ld_sh[31:0]};
            default: ld_data = '0;
        endcase
    end

    assign if_data = addr_lo[2] ? rdata[63:32] : rdata[31:0];

    always_comb begin
        mis = 1'b0;
        ill = 1'b0;
        if (is_if) begin
            mis = addr_lo[1:0] != 2'b00;
        end else begin
            mis = (addr_lo & align_mask(size)) != 3'b000;
            ill = wen ? memop[2] : (memop == 3'b111);
        end
        acc_err = mis | ill;
    end

endmodule

// File: rtl/ysyx_220066_mem_arb.sv
// IF / LS to single memory port arbiter, one access in flight.
// Round-robin grant, timeout in WAIT, registered one-cycle responses.
module ysyx_220066_mem_arb
    import ysyx_220066_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_wen,
    input  logic [2:0]  ls_memop,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    output logic        ls_resp_valid,
    output logic [63:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

    state_t state, state_nx;

    logic          last_grant;
    logic          owner_q;
    logic          wen_q;
    logic [2:0]    memop_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic          err_q;
    logic [63:0]   ls_rdata_q;
    logic [31:0]   if_rdata_q;
    logic [CW-1:0] cnt;

    logic        idle, issue, resp;
    logic        grant_ls, hs, timeout;
    logic        sel_is_if, sel_wen;
    logic [2:0]  sel_op;
    logic [63:0] sel_addr, sel_wdata;
    logic [63:0] st_data, ld_data;
    logic [7:0]  st_strb;
    logic [31:0] if_data;
    logic        acc_err;

    assign idle = state == ST_IDLE;

    always_comb begin
        grant_ls = 1'b0;
        unique case (1'b1)
            ls_req_valid && if_req_valid:
                grant_ls = last_grant == OWN_IF;
            ls_req_valid && !if_req_valid:
                grant_ls = 1'b1;
            default:
                grant_ls = 1'b0;
        endcase
    end

    assign if_req_ready = !rst && idle && if_req_valid && !grant_ls;
    assign ls_req_ready = !rst && idle && ls_req_valid && grant_ls;
    assign hs = if_req_ready || ls_req_ready;

    // The checker sees the live request in IDLE and the latched one later.
    always_comb begin
        if (idle) begin
            sel_is_if = !grant_ls;
            sel_wen   = grant_ls && ls_wen;
            sel_op    = grant_ls ? ls_memop : OP_LW;
            sel_addr  = grant_ls ? ls_addr : if_addr;
            sel_wdata = grant_ls ? ls_wdata : '0;
        end else begin
            sel_is_if = owner_q == OWN_IF;
            sel_wen   = wen_q;
            sel_op    = memop_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
    end

    ysyx_220066_mem_align u_align (
        .is_if   (sel_is_if),
        .wen     (sel_wen),
        .memop   (sel_op),
        .addr_lo (sel_addr[2:0]),
        .wdata   (sel_wdata),
        .rdata   (mem_rdata),
        .st_data (st_data),
        .st_strb (st_strb),
        .ld_data (ld_data),
        .if_data (if_data),
        .acc_err (acc_err)
    );

    assign timeout = (TIMEOUT_CYC != 0) && (cnt == TO_VAL);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:
                if (hs) state_nx = acc_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE:
                if (mem_req_ready) state_nx = ST_WAIT;
            ST_WAIT:
                if (mem_resp_valid || timeout) state_nx = ST_RESP;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_IF;
            owner_q    <= OWN_IF;
            wen_q      <= 1'b0;
            memop_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            ls_rdata_q <= '0;
            if_rdata_q <= '0;
            cnt        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (hs) begin
                    owner_q    <= grant_ls;
                    last_grant <= grant_ls;
                    wen_q      <= sel_wen;
                    memop_q    <= sel_op;
                    addr_q     <= sel_addr;
                    wdata_q    <= sel_wdata;
                    err_q      <= acc_err;
                    ls_rdata_q <= '0;
                    if_rdata_q <= '0;
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_resp_valid) begin
                        if (owner_q == OWN_LS)
                            ls_rdata_q <= wen_q ? '0 : ld_data;
                        else
                            if_rdata_q <= if_data;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign issue = !rst && state == ST_ISSUE;
    assign resp  = !rst && state == ST_RESP;

    assign mem_req_valid = issue;
    assign mem_wen       = issue && wen_q;
    assign mem_addr      = issue ? {addr_q[63:3], 3'b000} : '0;
    assign mem_wdata     = issue ? st_data : '0;
    assign mem_wstrb     = issue ? st_strb : '0;

    assign if_resp_valid = resp && owner_q == OWN_IF;
    assign ls_resp_valid = resp && owner_q == OWN_LS;
    assign if_rdata      = if_resp_valid ? if_rdata_q : '0;
    assign ls_rdata      = ls_resp_valid ? ls_rdata_q : '0;
    assign if_err        = if_resp_valid && err_q;
    assign ls_err        = ls_resp_valid && err_q;
    assign busy          = !rst && !idle;

endmodule
